// File: rtl/serial_subtractor_unit.sv
// serial_subtractor_unit
// Bit-serial unsigned subtractor computing A - B one bit per cycle, LSB first.
// Each step is a half-subtractor pair with a registered borrow between steps.
// The difference is presented serially (diff_bit/diff_bit_valid) and, once the
// run completes, as a parallel word with final borrow and a zero flag.
// All outputs are registered; ena=0 freezes every register.

module serial_subtractor_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_bit_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             brw_r;
  logic [1:0]       step_s;

  // One full-subtractor step built from two half-subtractors.
  // Returns {borrow_out, difference}.
  function automatic logic [1:0] sub_step(input logic x, input logic y, input logic c);
    logic d1;
    logic b1;
    logic d2;
    logic b2;
    d1 = x ^ y;
    b1 = ~x & y;
    d2 = d1 ^ c;
    b2 = ~d1 & c;
    return {b1 | b2, d2};
  endfunction

  // Combinational subtract step on the current operand LSBs and the borrow flop.
  always_comb begin
    step_s = sub_step(a_sr_r[0], b_sr_r[0], brw_r);
  end

  // Control FSM, serial datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      a_sr_r         <= {WIDTH{1'b0}};
      b_sr_r         <= {WIDTH{1'b0}};
      res_sr_r       <= {WIDTH{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      brw_r          <= 1'b0;
      busy           <= 1'b0;
      diff_bit       <= 1'b0;
      diff_bit_valid <= 1'b0;
      diff           <= {WIDTH{1'b0}};
      borrow         <= 1'b0;
      zero           <= 1'b0;
      done           <= 1'b0;
    end else if (ena) begin
      case (state_r)
        ST_IDLE: begin
          busy           <= 1'b0;
          done           <= 1'b0;
          diff_bit_valid <= 1'b0;
          if (start) begin
            a_sr_r  <= a;
            b_sr_r  <= b;
            brw_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          busy           <= 1'b1;
          done           <= 1'b0;
          diff_bit       <= step_s[0];
          diff_bit_valid <= 1'b1;
          a_sr_r         <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r         <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_sr_r       <= {step_s[0], res_sr_r[WIDTH-1:1]};
          brw_r          <= step_s[1];
          if (cnt_r == LAST_CNT) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1'b1);
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy           <= 1'b1;
          diff           <= res_sr_r;
          borrow         <= brw_r;
          zero           <= (res_sr_r == {WIDTH{1'b0}});
          done           <= 1'b1;
          diff_bit_valid <= 1'b0;
          state_r        <= ST_IDLE;
        end
        default: begin
          busy           <= 1'b0;
          done           <= 1'b0;
          diff_bit_valid <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_unit.sv
// Self-checking bench for serial_subtractor_unit (WIDTH = 8).
// Expected results come from plain modular arithmetic; expected serial timing
// comes from counting enabled clock edges since the accepted start.

module tb_serial_subtractor_unit;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         diff_bit;
  logic         diff_bit_valid;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         done;

  int n_vec;
  int n_bad;

  // Last completed result as the bench expects it to be held on the outputs.
  logic [W-1:0] last_d;
  logic         last_b;
  logic         last_z;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_d;
    logic         exp_b;
    logic         exp_z;
  } vec_t;

  vec_t tbl [6];

  serial_subtractor_unit #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .start          (start),
    .a              (a),
    .b              (b),
    .busy           (busy),
    .diff_bit       (diff_bit),
    .diff_bit_valid (diff_bit_valid),
    .diff           (diff),
    .borrow         (borrow),
    .zero           (zero),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_busy"},  {31'd0, busy}, 32'd0);
    chk({nm, "_bit"},   {31'd0, diff_bit}, 32'd0);
    chk({nm, "_valid"}, {31'd0, diff_bit_valid}, 32'd0);
    chk({nm, "_diff"},  {24'd0, diff}, 32'd0);
    chk({nm, "_borrow"},{31'd0, borrow}, 32'd0);
    chk({nm, "_zero"},  {31'd0, zero}, 32'd0);
    chk({nm, "_done"},  {31'd0, done}, 32'd0);
  endtask

  // Full operation: accept start, follow every edge, check serial bits, the
  // held previous result, the done pulse and its latency, then one idle edge.
  // gap_at/gap_len: after gap_at enabled RUN edges, hold ena low gap_len edges.
  // stray_at: assert start (a=1,b=1) for the enabled edge t+stray_at (0 = none).
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input int gap_at, input int gap_len, input int stray_at);
    logic [W-1:0] ed;
    logic         eb;
    logic         ez;
    int           k;
    int           total;
    int           gaps;
    ed = ta - tb;
    eb = (ta < tb);
    ez = (ed == {W{1'b0}});
    ena = 1'b1;
    a = ta;
    b = tb;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    chk("busy_at_t", {31'd0, busy}, 32'd0);
    chk("valid_at_t", {31'd0, diff_bit_valid}, 32'd0);
    k = 0;
    total = 0;
    gaps = 0;
    while (k < W + 1 && total < 40) begin
      if (gap_len > 0 && k == gap_at && gaps < gap_len) begin
        ena = 1'b0;
        gaps++;
      end else begin
        ena = 1'b1;
      end
      if (stray_at != 0 && ena && (k + 1) == stray_at) begin
        start = 1'b1;
        a = W'(1);
        b = W'(1);
      end else begin
        start = 1'b0;
      end
      tick();
      total++;
      if (ena) k++;
      start = 1'b0;
      if (k >= 1 && k <= W) begin
        chk("run_valid", {31'd0, diff_bit_valid}, 32'd1);
        chk("run_bit", {31'd0, diff_bit}, {31'd0, ed[k-1]});
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_done", {31'd0, done}, 32'd0);
        chk("run_diff_held", {24'd0, diff}, {24'd0, last_d});
        chk("run_borrow_held", {31'd0, borrow}, {31'd0, last_b});
      end else if (k == W + 1) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_valid", {31'd0, diff_bit_valid}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_diff", {24'd0, diff}, {24'd0, ed});
        chk("done_borrow", {31'd0, borrow}, {31'd0, eb});
        chk("done_zero", {31'd0, zero}, {31'd0, ez});
        chk("done_latency", total, W + 1 + gap_len);
      end
    end
    if (k < W + 1) begin
      chk("op_timeout", k, W + 1);
    end
    last_d = ed;
    last_b = eb;
    last_z = ez;
    ena = 1'b1;
    tick();
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid", {31'd0, diff_bit_valid}, 32'd0);
    chk("idle_diff", {24'd0, diff}, {24'd0, ed});
    chk("idle_zero", {31'd0, zero}, {31'd0, ez});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    last_d = '0;
    last_b = 1'b0;
    last_z = 1'b0;
    rst = 1'b1;
    ena = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    tbl[0] = '{8'd200, 8'd55,   8'd145,  1'b0, 1'b0};
    tbl[1] = '{8'd5,   8'd9,    8'hFC,   1'b1, 1'b0};
    tbl[2] = '{8'h3C,  8'h3C,   8'h00,   1'b0, 1'b1};
    tbl[3] = '{8'h00,  8'hFF,   8'h01,   1'b1, 1'b0};
    tbl[4] = '{8'hFF,  8'h00,   8'hFF,   1'b0, 1'b0};
    tbl[5] = '{8'h80,  8'h81,   8'hFF,   1'b1, 1'b0};

    // Reset overrides ena: outputs all zero.
    tick();
    tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    ena = 1'b1;
    tick();
    chk_idle_zero("post_reset_idle");

    // Table vectors: confirm the bench's arithmetic, then run each through the DUT.
    for (int i = 0; i < 6; i++) begin
      chk("tbl_model", {23'd0, tbl[i].va - tbl[i].vb, tbl[i].va < tbl[i].vb},
          {23'd0, tbl[i].exp_d, tbl[i].exp_b});
      do_op(tbl[i].va, tbl[i].vb, 0, 0, 0);
      chk("tbl_diff", {24'd0, diff}, {24'd0, tbl[i].exp_d});
      chk("tbl_borrow", {31'd0, borrow}, {31'd0, tbl[i].exp_b});
      chk("tbl_zero", {31'd0, zero}, {31'd0, tbl[i].exp_z});
    end

    // Stray start mid-run (a=1,b=1 at t+3) must be ignored.
    do_op(8'd200, 8'd55, 0, 0, 3);
    chk("stray_diff", {24'd0, diff}, 32'd145);

    // ena low for three cycles after four bits.
    do_op(8'd5, 8'd9, 4, 3, 0);

    // Reset mid-run at t+4: everything cleared, no done.
    a = 8'd77;
    b = 8'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_idle_zero("mid_rst");
    rst = 1'b0;
    tick();
    chk_idle_zero("mid_rst_after");
    last_d = '0;
    last_b = 1'b0;
    last_z = 1'b0;
    do_op(8'd77, 8'd12, 0, 0, 0);

    // Randomized operands with occasional enable gaps.
    for (int i = 0; i < 20; i++) begin
      int ga;
      int gl;
      ga = int'($urandom_range(1, W));
      gl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_op(W'($urandom), W'($urandom), ga, gl, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
